// File: rtl/board_led_ctrl.sv
// board_led_ctrl: heartbeat, blink and per-channel PWM LED driver.
// Define LED_CTRL_GAMMA_EN for square-law duty correction.
module board_led_ctrl #(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int CH_NUM      = 12,
  parameter int PWM_W       = 8,
  parameter int PRESC_DIV   = 4,
  parameter int BLINK_HZ    = 2,
  parameter int HB_HZ       = 1,
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [PWM_W-1:0]  cfg_duty,
  output logic [CH_NUM-1:0] led_o,
  output logic              heartbeat_o,
  output logic              frame_o
);

  localparam int BLINK_HALF = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int HB_HALF    = CLK_FREQ_HZ / (2 * HB_HZ);
  localparam int PS_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam int BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int HB_W = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_ON    = 2'd1,
    M_PWM   = 2'd2,
    M_BLINK = 2'd3
  } mode_e;

  logic [PS_W-1:0]  presc_q, presc_d;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic [BL_W-1:0]  blink_q, blink_d;
  logic             bph_q, bph_d;
  logic [HB_W-1:0]  hb_cnt_q, hb_cnt_d;
  logic             hb_q, hb_d;
  logic             frame_q, frame_d;
  logic [CH_NUM-1:0] led_q, led_d;
  logic [CH_NUM-1:0] cmp;

  mode_e [CH_NUM-1:0]            sh_mode_q, sh_mode_d;
  mode_e [CH_NUM-1:0]            act_mode_q, act_mode_d;
  logic  [CH_NUM-1:0][PWM_W-1:0] sh_duty_q, sh_duty_d;
  logic  [CH_NUM-1:0][PWM_W-1:0] act_duty_q, act_duty_d;

  logic step, bound, bl_wrap, hb_wrap;

  function automatic logic [PWM_W-1:0] eff_duty(
    input logic [PWM_W-1:0] d
  );
`ifdef LED_CTRL_GAMMA_EN
    logic [2*PWM_W-1:0] w;
    w = (2*PWM_W)'(d) * (2*PWM_W)'(d)
      + (2*PWM_W)'({PWM_W{1'b1}});
    return w[2*PWM_W-1:PWM_W];
`else
    return d;
`endif
  endfunction

  // Prescaler, PWM counter, blink and heartbeat timebases
  always_comb begin
    step     = (presc_q == PS_W'(PRESC_DIV - 1));
    bound    = step && (pwm_q == {PWM_W{1'b1}});
    presc_d  = step ? '0 : presc_q + 1'b1;
    pwm_d    = step ? pwm_q + 1'b1 : pwm_q;
    frame_d  = bound;
    bl_wrap  = (blink_q == BL_W'(BLINK_HALF - 1));
    blink_d  = bl_wrap ? '0 : blink_q + 1'b1;
    bph_d    = bph_q ^ bl_wrap;
    hb_wrap  = (hb_cnt_q == HB_W'(HB_HALF - 1));
    hb_cnt_d = hb_wrap ? '0 : hb_cnt_q + 1'b1;
    hb_d     = hb_q ^ hb_wrap;
  end

  // Shadow writes, frame-aligned active load, LED compare
  always_comb begin
    sh_mode_d  = sh_mode_q;
    sh_duty_d  = sh_duty_q;
    act_mode_d = act_mode_q;
    act_duty_d = act_duty_q;
    cmp        = '0;
    led_d      = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (bound) begin
        act_mode_d[i] = sh_mode_q[i];
        act_duty_d[i] = sh_duty_q[i];
      end
      if (cfg_we && (cfg_ch == CH_W'(i))) begin
        sh_mode_d[i] = mode_e'(cfg_mode);
        sh_duty_d[i] = cfg_duty;
      end
      cmp[i] = (pwm_q < eff_duty(act_duty_q[i]));
      unique case (act_mode_q[i])
        M_OFF:   led_d[i] = 1'b0;
        M_ON:    led_d[i] = 1'b1;
        M_PWM:   led_d[i] = cmp[i];
        M_BLINK: led_d[i] = cmp[i] & bph_q;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      presc_q    <= '0;
      pwm_q      <= '0;
      blink_q    <= '0;
      bph_q      <= 1'b0;
      hb_cnt_q   <= '0;
      hb_q       <= 1'b0;
      frame_q    <= 1'b0;
      led_q      <= '0;
      sh_mode_q  <= {CH_NUM{M_OFF}};
      act_mode_q <= {CH_NUM{M_OFF}};
      sh_duty_q  <= '0;
      act_duty_q <= '0;
    end else begin
      presc_q    <= presc_d;
      pwm_q      <= pwm_d;
      blink_q    <= blink_d;
      bph_q      <= bph_d;
      hb_cnt_q   <= hb_cnt_d;
      hb_q       <= hb_d;
      frame_q    <= frame_d;
      led_q      <= led_d;
      sh_mode_q  <= sh_mode_d;
      act_mode_q <= act_mode_d;
      sh_duty_q  <= sh_duty_d;
      act_duty_q <= act_duty_d;
    end
  end

  assign led_o       = led_q;
  assign heartbeat_o = hb_q;
  assign frame_o     = frame_q;

endmodule

// File: tb/tb_board_led_ctrl.sv
// tb_board_led_ctrl: scoreboard bench for board_led_ctrl.
// Expected outputs are queued per cycle and checked one edge later.
`timescale 1ns/1ps
module tb_board_led_ctrl;

  localparam int FR = 32;
  localparam int BH = 100;
  localparam int HH = 200;
`ifdef LED_CTRL_GAMMA_EN
  localparam int CH0_EXP = 2;
  localparam int CH3_EXP = 8;
`else
  localparam int CH0_EXP = 8;
  localparam int CH3_EXP = 16;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       we = 1'b0;
  logic [1:0] ch = '0;
  logic [1:0] md = '0;
  logic [3:0] dt = '0;
  logic [3:0] led;
  logic       hb, fr;

  logic       rst2 = 1'b1;
  logic       we2 = 1'b0;
  logic [1:0] ch2 = '0;
  logic [1:0] md2 = '0;
  logic [3:0] dt2 = '0;
  logic [2:0] led2;
  logic       hb2, fr2;

  board_led_ctrl #(
    .CLK_FREQ_HZ(400), .CH_NUM(4), .PWM_W(4),
    .PRESC_DIV(2), .BLINK_HZ(2), .HB_HZ(1)
  ) u_dut (
    .sys_clk(clk), .sys_rst(rst), .cfg_we(we),
    .cfg_ch(ch), .cfg_mode(md), .cfg_duty(dt),
    .led_o(led), .heartbeat_o(hb), .frame_o(fr)
  );

  board_led_ctrl #(
    .CLK_FREQ_HZ(400), .CH_NUM(3), .PWM_W(4),
    .PRESC_DIV(2), .BLINK_HZ(2), .HB_HZ(1)
  ) u_dut3 (
    .sys_clk(clk), .sys_rst(rst2), .cfg_we(we2),
    .cfg_ch(ch2), .cfg_mode(md2), .cfg_duty(dt2),
    .led_o(led2), .heartbeat_o(hb2), .frame_o(fr2)
  );

  typedef struct packed {
    logic [3:0] led;
    logic       hb;
    logic       fr;
  } exp_t;

  exp_t       exp_q[$];
  int         n_chk = 0;
  int         n_err = 0;
  int         m_t = 0;
  logic [1:0] sh_m[4], ac_m[4];
  int         sh_d[4], ac_d[4];
  int         cnt_l[4];
  int         cnt_fr = 0;
  int         hb_rise = -1;
  int         first_fr = -1;
  logic       prev_hb = 1'b0;
  logic [3:0] last_led = '0;
  int         t0, ex;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h t=%0d",
               tag, got, exp, m_t);
    end
  endtask

  function automatic int eff(input int d);
`ifdef LED_CTRL_GAMMA_EN
    return (d * d + 15) / 16;
`else
    return d;
`endif
  endfunction

  task automatic clr();
    for (int k = 0; k < 4; k++) cnt_l[k] = 0;
    cnt_fr = 0;
  endtask

  task automatic step(input logic r, input logic w,
                      input logic [1:0] c,
                      input logic [1:0] m,
                      input logic [3:0] d);
    exp_t e, n;
    int   pw;
    logic ph, on;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("led", 32'(led), 32'(e.led));
      chk("heartbeat", 32'(hb), 32'(e.hb));
      chk("frame", 32'(fr), 32'(e.fr));
      last_led = led;
      for (int k = 0; k < 4; k++) cnt_l[k] += int'(led[k]);
      cnt_fr += int'(fr);
      if (hb && !prev_hb && hb_rise < 0) hb_rise = m_t;
      if (fr && first_fr < 0) first_fr = m_t;
      prev_hb = hb;
    end
    rst = r; we = w; ch = c; md = m; dt = d;
    n = '0;
    if (r) begin
      m_t = 0;
      for (int k = 0; k < 4; k++) begin
        sh_m[k] = 0; ac_m[k] = 0;
        sh_d[k] = 0; ac_d[k] = 0;
      end
    end else begin
      pw = (m_t / 2) % 16;
      ph = ((m_t / BH) % 2) == 1;
      for (int k = 0; k < 4; k++) begin
        on = (pw < eff(ac_d[k]));
        case (ac_m[k])
          2'd0: n.led[k] = 1'b0;
          2'd1: n.led[k] = 1'b1;
          2'd2: n.led[k] = on;
          default: n.led[k] = on && ph;
        endcase
      end
      n.hb = (((m_t + 1) / HH) % 2) == 1;
      n.fr = (m_t % FR) == FR - 1;
      if (n.fr) begin
        for (int k = 0; k < 4; k++) begin
          ac_m[k] = sh_m[k];
          ac_d[k] = sh_d[k];
        end
      end
      if (w) begin
        sh_m[c] = m;
        sh_d[c] = int'(d);
      end
      m_t++;
    end
    exp_q.push_back(n);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 2'd0, 2'd0, 4'd0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      sh_m[k] = 0; ac_m[k] = 0; sh_d[k] = 0; ac_d[k] = 0;
    end
    repeat (3) step(1'b1, 1'b0, 2'd0, 2'd0, 4'd0);
    rst2 = 1'b0;
    clr();
    hb_rise = -1;
    first_fr = -1;

    idle(1001);
    chk("hb_first_rise", 32'(hb_rise), 32'd200);
    chk("idle_frames", 32'(cnt_fr), 32'd31);
    chk("idle_leds", 32'(cnt_l[0] + cnt_l[1] + cnt_l[2] + cnt_l[3]), 0);

    we2 = 1'b1; ch2 = 2'd2; md2 = 2'd1; dt2 = 4'd0;
    idle(1);
    we2 = 1'b1; ch2 = 2'd3; md2 = 2'd1; dt2 = 4'd0;
    idle(1);
    we2 = 1'b0;

    step(1'b0, 1'b1, 2'd0, 2'd2, 4'd4);
    idle(64);
    clr();
    idle(32);
    chk("ch0_pwm4", 32'(cnt_l[0]), 32'(CH0_EXP));
    chk("oor_write", 32'(led2), 32'b100);

    while (m_t % FR != FR - 1) idle(1);
    step(1'b0, 1'b1, 2'd1, 2'd1, 4'd0);
    clr();
    idle(33);
    chk("ch1_hold", 32'(cnt_l[1]), 0);
    idle(1);
    chk("ch1_on", 32'(last_led[1]), 1);

    step(1'b0, 1'b1, 2'd2, 2'd3, 4'd15);
    idle(100);
    while (m_t % (2 * BH) != 1) idle(1);
    clr();
    idle(100);
    chk("blink_off", 32'(cnt_l[2]), 0);
    t0 = m_t - 1;
    ex = 0;
    for (int t = t0; t < t0 + 100; t++)
      if (((t / 2) % 16) < eff(15)) ex++;
    clr();
    idle(100);
    chk("blink_on", 32'(cnt_l[2]), 32'(ex));

    step(1'b0, 1'b1, 2'd3, 2'd2, 4'd8);
    idle(64);
    clr();
    idle(32);
    chk("ch3_pwm8", 32'(cnt_l[3]), 32'(CH3_EXP));
    step(1'b0, 1'b1, 2'd3, 2'd2, 4'd15);
    idle(64);
    clr();
    idle(32);
    chk("ch3_pwm15", 32'(cnt_l[3]), 32'd30);

    while (m_t % FR != 5) idle(1);
    step(1'b0, 1'b1, 2'd0, 2'd1, 4'd0);
    idle(4);
    repeat (2) step(1'b1, 1'b0, 2'd0, 2'd0, 4'd0);
    first_fr = -1;
    clr();
    idle(70);
    chk("rst_first_frame", 32'(first_fr), 32'd32);
    chk("rst_leds", 32'(cnt_l[0] + cnt_l[1] + cnt_l[2] + cnt_l[3]), 0);
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
